// File: rtl/if_stage_if.sv
// Instruction-memory read port between the fetch stage and the instruction memory.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage with IF/ID register and a one-entry skid buffer
// that absorbs decode stalls and slow instruction memory without losing words.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_id,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    if_stage_if.master       imem,
    output logic [31:0]      ifid_instr,
    output logic [31:0]      ifid_pc,
    output logic [31:0]      ifid_pc_plus4,
    output logic             ifid_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic {
        FETCH    = 1'b0,
        BUFFERED = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_reg, state_next;
    logic [31:0]       pc_reg, pc_next;
    logic [31:0]       skid_instr_reg, skid_instr_next;
    logic [31:0]       skid_pc_reg, skid_pc_next;
    logic [31:0]       instr_reg, instr_next;
    logic [31:0]       ifpc_reg, ifpc_next;
    logic [31:0]       ifpc4_reg, ifpc4_next;
    logic              valid_reg, valid_next;
    logic              misalign_reg, misalign_next;
    logic [CNT_W-1:0]  bubble_reg, bubble_next;
    logic [31:0]       pc_plus4;

    assign pc_plus4 = pc_reg + 32'd4;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a redirect always returns to FETCH and drops the skid
    always_comb begin
        state_next = state_reg;
        if (redirect) begin
            state_next = FETCH;
        end else if (stall_id) begin
            if (state_reg == FETCH && imem.imem_ready) begin
                state_next = BUFFERED;
            end
        end else if (state_reg == BUFFERED) begin
            state_next = FETCH;
        end
    end

    // Datapath next values
    always_comb begin
        pc_next         = pc_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc_next    = skid_pc_reg;
        instr_next      = instr_reg;
        ifpc_next       = ifpc_reg;
        ifpc4_next      = ifpc4_reg;
        valid_next      = valid_reg;
        misalign_next   = misalign_reg;
        bubble_next     = bubble_reg;

        if (redirect) begin
            pc_next       = {redirect_pc[31:2], 2'b00};
            misalign_next = misalign_reg | (redirect_pc[1:0] != 2'b00);
            valid_next    = 1'b0;
            instr_next    = NOP_INSTR;
        end else if (stall_id) begin
            // IF/ID holds; a word arriving now is parked so it is not lost
            if (state_reg == FETCH && imem.imem_ready) begin
                skid_instr_next = imem.imem_rdata;
                skid_pc_next    = pc_reg;
                pc_next         = pc_plus4;
            end
        end else if (state_reg == BUFFERED) begin
            instr_next = skid_instr_reg;
            ifpc_next  = skid_pc_reg;
            ifpc4_next = skid_pc_reg + 32'd4;
            valid_next = 1'b1;
        end else if (imem.imem_ready) begin
            instr_next = imem.imem_rdata;
            ifpc_next  = pc_reg;
            ifpc4_next = pc_plus4;
            valid_next = 1'b1;
            pc_next    = pc_plus4;
        end else begin
            valid_next = 1'b0;
            instr_next = NOP_INSTR;
            if (bubble_reg != {CNT_W{1'b1}}) begin
                bubble_next = bubble_reg + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg         <= RESET_PC;
            skid_instr_reg <= NOP_INSTR;
            skid_pc_reg    <= 32'h0000_0000;
            instr_reg      <= NOP_INSTR;
            ifpc_reg       <= 32'h0000_0000;
            ifpc4_reg      <= 32'h0000_0000;
            valid_reg      <= 1'b0;
            misalign_reg   <= 1'b0;
            bubble_reg     <= '0;
        end else begin
            pc_reg         <= pc_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc_reg    <= skid_pc_next;
            instr_reg      <= instr_next;
            ifpc_reg       <= ifpc_next;
            ifpc4_reg      <= ifpc4_next;
            valid_reg      <= valid_next;
            misalign_reg   <= misalign_next;
            bubble_reg     <= bubble_next;
        end
    end

    // Outputs; the request is gated by reset so nothing is issued while held
    always_comb begin
        imem.imem_req  = reset && (state_reg == FETCH);
        imem.imem_addr = pc_reg;
        ifid_instr     = instr_reg;
        ifid_pc        = ifpc_reg;
        ifid_pc_plus4  = ifpc4_reg;
        ifid_valid     = valid_reg;
        misalign_err   = misalign_reg;
        bubble_cnt     = bubble_reg;
    end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: driver queues expected IF/ID words, a monitor
// retires them as decode accepts; a second instance checks PC wrap-around.
module tb_if_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_id;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;
    logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4;
    logic        ifid_valid, misalign_err;
    logic [15:0] bubble_cnt;

    logic        reset_w;
    logic [31:0] w_instr, w_pc, w_pc4;
    logic        w_valid, w_mis;
    logic [15:0] w_bub;

    int   checks   = 0;
    int   failures = 0;
    logic last_stall = 1'b0;
    logic wrap_done  = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    if_stage_if imem_bus ();
    if_stage_if wrap_bus ();

    // Memory model: word[i] = 0x20000000 + i
    assign imem_bus.imem_rdata = 32'h2000_0000 + {2'b00, imem_bus.imem_addr[31:2]};
    assign imem_bus.imem_ready = ready;
    assign wrap_bus.imem_rdata = 32'h2000_0000 + {2'b00, wrap_bus.imem_addr[31:2]};
    assign wrap_bus.imem_ready = 1'b1;

    if_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall_id      (stall_id),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem          (imem_bus),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid),
        .misalign_err  (misalign_err),
        .bubble_cnt    (bubble_cnt)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk           (clk),
        .reset         (reset_w),
        .stall_id      (1'b0),
        .redirect      (1'b0),
        .redirect_pc   (32'h0000_0000),
        .imem          (wrap_bus),
        .ifid_instr    (w_instr),
        .ifid_pc       (w_pc),
        .ifid_pc_plus4 (w_pc4),
        .ifid_valid    (w_valid),
        .misalign_err  (w_mis),
        .bubble_cnt    (w_bub)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc);
        exp_q.push_back('{instr: instr, pc: pc, pc4: pc + 32'd4});
    endtask

    // Apply inputs for the next edge, return at the following falling edge
    task automatic step(input logic s, input logic r, input logic rd, input logic [31:0] rpc);
        stall_id    = s;
        ready       = r;
        redirect    = rd;
        redirect_pc = rpc;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: a valid IF/ID after an unstalled edge is a newly accepted instruction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            last_stall = stall_id;
            @(negedge clk);
            if (ifid_valid && !last_stall) begin
                $display("txn pc=%h instr=%h pc4=%h", ifid_pc, ifid_instr, ifid_pc_plus4);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_txn actual=%h required=none", ifid_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("txn_instr", ifid_instr, e.instr);
                    chk("txn_pc", ifid_pc, e.pc);
                    chk("txn_pc4", ifid_pc_plus4, e.pc4);
                end
            end
        end
    end

    // PC wrap-around on the second instance
    initial begin
        reset_w = 1'b0;
        repeat (2) @(negedge clk);
        reset_w = 1'b1;
        @(negedge clk);
        chk("wrap0_valid", {31'b0, w_valid}, 32'h1);
        chk("wrap0_pc", w_pc, 32'hFFFF_FFF8);
        chk("wrap0_instr", w_instr, 32'h5FFF_FFFE);
        @(negedge clk);
        chk("wrap1_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap1_pc4", w_pc4, 32'h0000_0000);
        chk("wrap1_instr", w_instr, 32'h5FFF_FFFF);
        @(negedge clk);
        chk("wrap2_pc", w_pc, 32'h0000_0000);
        chk("wrap2_instr", w_instr, 32'h2000_0000);
        wrap_done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        stall_id    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ready       = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_pc", ifid_pc, 32'h0);
        chk("rst_req", {31'b0, imem_bus.imem_req}, 32'h0);
        chk("rst_addr", imem_bus.imem_addr, 32'h0);
        chk("rst_bubble", {16'b0, bubble_cnt}, 32'h0);

        // Release reset with memory always ready
        push_exp(32'h2000_0000, 32'h00);
        push_exp(32'h2000_0001, 32'h04);
        push_exp(32'h2000_0002, 32'h08);
        push_exp(32'h2000_0003, 32'h0C);
        reset = 1'b1;
        repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("addr_at_10", imem_bus.imem_addr, 32'h10);

        // Slow memory at pc 0x10
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            chk("slow_valid", {31'b0, ifid_valid}, 32'h0);
            chk("slow_instr", ifid_instr, 32'h0);
        end
        chk("slow_bubble", {16'b0, bubble_cnt}, 32'd4);
        push_exp(32'h2000_0004, 32'h10);
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // Decode stall for three cycles while memory is ready
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            chk("stall_pc_hold", ifid_pc, 32'h10);
            chk("stall_req", {31'b0, imem_bus.imem_req}, 32'h0);
            chk("stall_addr", imem_bus.imem_addr, 32'h18);
        end
        push_exp(32'h2000_0005, 32'h14);
        push_exp(32'h2000_0006, 32'h18);
        push_exp(32'h2000_0007, 32'h1C);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);

        // Redirect while buffered and stalled
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("buf_req", {31'b0, imem_bus.imem_req}, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h40);
        chk("redir_valid", {31'b0, ifid_valid}, 32'h0);
        chk("redir_instr", ifid_instr, 32'h0);
        chk("redir_addr", imem_bus.imem_addr, 32'h40);
        chk("redir_req", {31'b0, imem_bus.imem_req}, 32'h1);
        chk("redir_mis", {31'b0, misalign_err}, 32'h0);
        push_exp(32'h2000_0010, 32'h40);
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // Misaligned redirect target
        step(1'b0, 1'b1, 1'b1, 32'h42);
        chk("mis_addr", imem_bus.imem_addr, 32'h40);
        chk("mis_flag", {31'b0, misalign_err}, 32'h1);
        chk("mis_valid", {31'b0, ifid_valid}, 32'h0);
        push_exp(32'h2000_0010, 32'h40);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("mis_sticky", {31'b0, misalign_err}, 32'h1);

        // Asynchronous reset while buffered
        step(1'b1, 1'b1, 1'b0, 32'h0);
        #2 reset = 1'b0;
        #1;
        chk("arst_req", {31'b0, imem_bus.imem_req}, 32'h0);
        chk("arst_addr", imem_bus.imem_addr, 32'h0);
        chk("arst_valid", {31'b0, ifid_valid}, 32'h0);
        chk("arst_instr", ifid_instr, 32'h0);
        chk("arst_pc", ifid_pc, 32'h0);
        chk("arst_pc4", ifid_pc_plus4, 32'h0);
        chk("arst_mis", {31'b0, misalign_err}, 32'h0);
        chk("arst_bubble", {16'b0, bubble_cnt}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        push_exp(32'h2000_0000, 32'h00);
        push_exp(32'h2000_0001, 32'h04);
        repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0);

        // Drain: hold decode so no further acceptances occur
        stall_id = 1'b1;
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("wrap_done", {31'b0, wrap_done}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
